// File: rtl/prn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prn_seq_ctrl
// Brief    : Seed collection, serial load and chip stepping for the 115-bit
//            JNAV PRN generator, with per-period epoch and optional reload.
// Revision : 1.0 - initial release
// ============================================================================
module prn_seq_ctrl #(
    parameter int STATE_BITS = 115,
    parameter int SEED_BYTES = 15,
    parameter int CODE_LEN   = 10230,
    parameter int CNT_W      = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [7:0]       seed_data,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             chip_en,
    output logic             gen_load,
    output logic             gen_data,
    output logic             gen_run,
    output logic [CNT_W-1:0] chip_cnt,
    output logic             epoch,
    output logic             done,
    output logic             busy
);

    localparam int BYTE_W = (SEED_BYTES > 1) ? $clog2(SEED_BYTES) : 1;
    localparam int BIT_W  = $clog2(STATE_BITS);

    localparam logic [BYTE_W-1:0] c_last_byte = BYTE_W'(SEED_BYTES - 1);
    localparam logic [BIT_W-1:0]  c_last_bit  = BIT_W'(STATE_BITS - 1);
    localparam logic [CNT_W-1:0]  c_last_chip = CNT_W'(CODE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_SHIFT   = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                  r_state;
    logic [STATE_BITS-1:0]   r_seed;
    logic [BYTE_W-1:0]       r_byte_cnt;
    logic [BIT_W-1:0]        r_bit_cnt;

    state_t                  w_state;
    logic [STATE_BITS-1:0]   w_seed;
    logic [STATE_BITS-1:0]   w_seed_shift;
    logic [BYTE_W-1:0]       w_byte_cnt;
    logic [BIT_W-1:0]        w_bit_cnt;
    logic [BIT_W-1:0]        w_rd_idx;
    logic [CNT_W-1:0]        w_chip_cnt;
    logic                    w_load;
    logic                    w_data;
    logic                    w_run;
    logic                    w_epoch;
    logic                    w_done;

    // Bytes shift in from the bottom; the unused top bits of byte 0 fall off
    // the end, leaving byte 0[2:0] in the seed MSBs once all bytes are in.
    assign w_seed_shift = {r_seed[STATE_BITS-9:0], seed_data};
    // Bit presented on the cycle after the one currently on gen_data.
    assign w_rd_idx     = c_last_bit - r_bit_cnt - BIT_W'(1);

    always_comb begin
        w_state    = r_state;
        w_seed     = r_seed;
        w_byte_cnt = r_byte_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_chip_cnt = chip_cnt;
        w_load     = 1'b0;
        w_data     = 1'b0;
        w_run      = 1'b0;
        w_epoch    = 1'b0;
        w_done     = 1'b0;

        if (abort) begin
            w_state    = S_IDLE;
            w_byte_cnt = '0;
            w_bit_cnt  = '0;
            w_chip_cnt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_byte_cnt = '0;
                    w_bit_cnt  = '0;
                    if (start) begin
                        w_state = S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (seed_valid && seed_ready) begin
                        w_seed     = w_seed_shift;
                        w_byte_cnt = r_byte_cnt + BYTE_W'(1);
                        if (r_byte_cnt == c_last_byte) begin
                            w_state    = S_SHIFT;
                            w_byte_cnt = '0;
                            w_bit_cnt  = '0;
                            w_load     = 1'b1;
                            w_data     = w_seed_shift[STATE_BITS-1];
                        end
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == c_last_bit) begin
                        w_state    = S_RUN;
                        w_chip_cnt = '0;
                    end else begin
                        w_bit_cnt = r_bit_cnt + BIT_W'(1);
                        w_load    = 1'b1;
                        w_data    = r_seed[w_rd_idx];
                    end
                end
                S_RUN: begin
                    if (chip_en) begin
                        w_run = 1'b1;
                        if (chip_cnt == c_last_chip) begin
                            w_chip_cnt = '0;
                            w_epoch    = 1'b1;
                            if (repeat_en) begin
                                // Reload starts in the same cycle as the final chip pulse.
                                w_state   = S_SHIFT;
                                w_bit_cnt = '0;
                                w_load    = 1'b1;
                                w_data    = r_seed[STATE_BITS-1];
                            end else begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end
                        end else begin
                            w_chip_cnt = chip_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_seed     <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            seed_ready <= 1'b0;
            gen_load   <= 1'b0;
            gen_data   <= 1'b0;
            gen_run    <= 1'b0;
            chip_cnt   <= '0;
            epoch      <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_seed     <= w_seed;
            r_byte_cnt <= w_byte_cnt;
            r_bit_cnt  <= w_bit_cnt;
            seed_ready <= (w_state == S_COLLECT);
            gen_load   <= w_load;
            gen_data   <= w_data;
            gen_run    <= w_run;
            chip_cnt   <= w_chip_cnt;
            epoch      <= w_epoch;
            done       <= w_done;
            busy       <= (w_state != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prn_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prn_seq_ctrl
// Brief    : Directed self-checking bench for prn_seq_ctrl (CODE_LEN = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prn_seq_ctrl;

    localparam int SB    = 115;
    localparam int NB    = 15;
    localparam int CL    = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          repeat_en = 1'b0;
    logic [7:0]    seed_data = 8'h00;
    logic          seed_valid = 1'b0;
    logic          seed_ready;
    logic          chip_en = 1'b0;
    logic          gen_load;
    logic          gen_data;
    logic          gen_run;
    logic [CW-1:0] chip_cnt;
    logic          epoch;
    logic          done;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    int            load_cycles = 0;
    int            runs;
    logic          exp_q[$];
    logic [7:0]    cur_bytes[NB];
    logic [SB-1:0] exp_seed;

    prn_seq_ctrl #(
        .STATE_BITS(SB),
        .SEED_BYTES(NB),
        .CODE_LEN  (CL),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .repeat_en (repeat_en),
        .seed_data (seed_data),
        .seed_valid(seed_valid),
        .seed_ready(seed_ready),
        .chip_en   (chip_en),
        .gen_load  (gen_load),
        .gen_data  (gen_data),
        .gen_run   (gen_run),
        .chip_cnt  (chip_cnt),
        .epoch     (epoch),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({seed_ready, gen_load, gen_data, gen_run, chip_cnt, epoch, done, busy});
    endfunction

    // Byte-to-bit placement written directly from the seed mapping.
    function automatic logic [SB-1:0] seed_of_bytes();
        logic [SB-1:0] s = '0;
        s[114:112] = cur_bytes[0][2:0];
        for (int k = 1; k < NB; k++) begin
            s[111 - 8*(k-1) -: 8] = cur_bytes[k];
        end
        return s;
    endfunction

    task automatic push_seed(input logic [SB-1:0] s);
        for (int i = SB - 1; i >= 0; i--) begin
            exp_q.push_back(s[i]);
        end
    endtask

    // Scoreboard: every load cycle consumes one expected serial bit.
    always @(negedge clk) begin
        if (rst_n && gen_load) begin
            load_cycles++;
            if (exp_q.size() == 0) begin
                check("load_extra", 32'(gen_load), 32'd0);
            end else begin
                check("gen_data", 32'(gen_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Returns #1 after the edge that accepts the last byte.
    task automatic send_seed(input bit gaps);
        int g;
        load_cycles = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("ready_collect", 32'({seed_ready, busy}), 32'd3);
        for (int k = 0; k < NB; k++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    seed_valid = 1'b0;
                    seed_data  = 8'($urandom);
                    start      = 1'b1;
                    @(posedge clk); #1;
                end
                start = 1'b0;
            end
            seed_valid = 1'b1;
            seed_data  = cur_bytes[k];
            @(posedge clk); #1;
        end
        seed_valid = 1'b0;
        seed_data  = 8'h00;
        check("load_start", 32'({gen_load, seed_ready}), 32'd2);
    endtask

    // Waits for gen_load to fall; counts stray run/epoch/done pulses after cycle 1.
    task automatic wait_load_end(output int stray);
        int guard = 0;
        stray = 0;
        @(negedge clk);
        while (gen_load && guard < 300) begin
            if (gen_run || epoch || done) stray++;
            guard++;
            @(negedge clk);
        end
        check("load_timeout", 32'(guard < 300), 32'd1);
    endtask

    task automatic run_chips(input int spacing, input bit rep);
        for (int i = 0; i < CL; i++) begin
            chip_en = 1'b1;
            @(negedge clk);
            chip_en = 1'b0;
            check("chip_run",   32'(gen_run), 32'd1);
            check("chip_cnt",   32'(chip_cnt), 32'((i + 1) % CL));
            check("chip_epoch", 32'(epoch), 32'(i == CL - 1));
            check("chip_done",  32'(done), 32'((i == CL - 1) && !rep));
            if (i == CL - 1) begin
                check("end_busy", 32'(busy), 32'(rep));
                check("end_load", 32'(gen_load), 32'(rep));
            end else begin
                for (int g = 1; g < spacing; g++) begin
                    @(negedge clk);
                    check("chip_gap", 32'({gen_run, epoch, done}), 32'd0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        #12 check("in_reset", outs(), 32'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", outs(), 32'd0);
        chip_en    = 1'b1;
        seed_valid = 1'b1;
        seed_data  = 8'hA5;
        repeat (4) begin
            @(negedge clk);
            check("idle_hold", outs(), 32'd0);
        end
        chip_en    = 1'b0;
        seed_valid = 1'b0;

        // Seed ordering, gap-free, then a non-repeating period every third cycle
        cur_bytes[0] = 8'hFF;
        cur_bytes[1] = 8'h00;
        cur_bytes[2] = 8'h80;
        for (int k = 3; k < NB - 1; k++) cur_bytes[k] = 8'h00;
        cur_bytes[NB-1] = 8'h01;
        exp_seed = '0;
        exp_seed[114:112] = 3'b111;
        exp_seed[103] = 1'b1;
        exp_seed[0] = 1'b1;
        push_seed(exp_seed);
        send_seed(1'b0);
        wait_load_end(runs);
        check("load_len_a", 32'(load_cycles), 32'd115);
        check("q_empty_a", 32'(exp_q.size()), 32'd0);
        check("stray_a", 32'(runs), 32'd0);
        check("run_entry_a", 32'({busy, chip_cnt}), 32'h10);
        repeat_en = 1'b0;
        run_chips(3, 1'b0);
        @(negedge clk);
        check("post_done", outs(), 32'd0);

        // Same seed with random gaps and start held during COLLECT, then repeat
        push_seed(exp_seed);
        send_seed(1'b1);
        wait_load_end(runs);
        check("load_len_b", 32'(load_cycles), 32'd115);
        check("q_empty_b", 32'(exp_q.size()), 32'd0);
        check("stray_b", 32'(runs), 32'd0);
        repeat_en = 1'b1;
        push_seed(exp_seed);
        load_cycles = 0;
        run_chips(3, 1'b1);
        chip_en = 1'b1;
        wait_load_end(runs);
        chip_en = 1'b0;
        check("reload_len", 32'(load_cycles), 32'd115);
        check("reload_q", 32'(exp_q.size()), 32'd0);
        check("reload_stray", 32'(runs), 32'd0);
        check("reload_cnt", 32'({busy, chip_cnt}), 32'h10);
        repeat_en = 1'b0;
        run_chips(1, 1'b0);
        @(negedge clk);
        check("post_done_b", outs(), 32'd0);

        // Abort at load cycle 50
        for (int k = 0; k < NB; k++) cur_bytes[k] = 8'($urandom);
        push_seed(seed_of_bytes());
        send_seed(1'b0);
        for (int n = 1; n <= 50; n++) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_idle", outs(), 32'd0);
        check("abort_q", 32'(exp_q.size()), 32'd65);
        exp_q.delete();
        repeat (4) begin
            @(negedge clk);
            check("abort_quiet", outs(), 32'd0);
        end

        // Fresh collect with gaps, then asynchronous reset during RUN
        for (int k = 0; k < NB; k++) cur_bytes[k] = 8'($urandom);
        push_seed(seed_of_bytes());
        send_seed(1'b1);
        wait_load_end(runs);
        check("load_len_e", 32'(load_cycles), 32'd115);
        check("q_empty_e", 32'(exp_q.size()), 32'd0);
        chip_en = 1'b1;
        @(posedge clk); #2 chip_en = 1'b0;
        check("pre_reset_run", 32'({gen_run, chip_cnt}), 32'h11);
        #1 rst_n = 1'b0;
        #1 check("async_reset", outs(), 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("after_reset_e", outs(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
